// File: rtl/im_pkg.sv
// im_pkg: ISA constants shared with the CPU and the loader state encoding.
package im_pkg;
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_HALT = 5'd1;
  localparam logic [4:0] OP_LDI  = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_LD   = 5'd8;
  localparam logic [4:0] OP_ST   = 5'd9;
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_JMP  = 5'd11;
  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;
  localparam logic [15:0] HALT_WORD = {OP_HALT, 11'd0};
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: byte-wide download port plus instruction fetch port.
interface im_loader_if #(parameter int ADDR_W = 8, parameter int DATA_W = 16);
  logic              ld_start;
  logic [7:0]        ld_byte;
  logic              ld_valid;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              ld_err;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              f_valid;
  logic              run;
  modport master (
    output ld_start, ld_byte, ld_valid, ld_last, f_req, f_addr,
    input  ld_ready, ld_count, ld_err, f_data, f_valid, run
  );
  modport slave (
    input  ld_start, ld_byte, ld_valid, ld_last, f_req, f_addr,
    output ld_ready, ld_count, ld_err, f_data, f_valid, run
  );
endinterface

// File: rtl/im_word_ram.sv
// im_word_ram: DEPTH x DATA_W storage, one synchronous write and one synchronous read port.
module im_word_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/im_loader.sv
// im_loader: downloadable instruction memory; unwritten words fetch as HALT.
module im_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(im_pkg::HALT_WORD)
) (
  input logic  clock,
  input logic  reset,
  im_loader_if.slave bus
);
  import im_pkg::*;
  localparam int BYTES = DATA_W / 8;
  localparam int PW    = BYTES > 1 ? $clog2(BYTES) : 1;
  state_t                 state, state_n;
  logic [PW-1:0]          phase;
  logic [DATA_W-1:0]      asm_q, sh, wr_word;
  logic [(2**ADDR_W)-1:0] valid;
  logic [ADDR_W:0]        cnt;
  logic                   err, fv, hit, accept, done, full, we, fire;
  logic [DATA_W-1:0]      ram_q;
  assign accept  = bus.ld_valid && state == LOAD && !bus.ld_start;
  assign done    = accept && (phase == PW'(BYTES - 1) || bus.ld_last);
  assign full    = cnt == (ADDR_W+1)'(DEPTH);
  assign we      = done && !full;
  assign fire    = bus.f_req && state != LOAD && !bus.ld_start;
  assign sh      = DATA_W'({asm_q, bus.ld_byte});
  // a short final word is left-justified so its missing low bytes read as zero
  assign wr_word = sh << (8 * (BYTES - 1 - int'(phase)));
  always_comb begin
    state_n = state;
    if (bus.ld_start) state_n = LOAD;
    else if (accept && bus.ld_last) state_n = RUN;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= '0;
      asm_q <= '0;
      valid <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      fv    <= 1'b0;
      hit   <= 1'b0;
    end else begin
      state <= state_n;
      fv    <= fire;
      if (fire) hit <= valid[bus.f_addr];
      if (bus.ld_start) begin
        valid <= '0;
        cnt   <= '0;
        err   <= 1'b0;
        phase <= '0;
      end else if (accept) begin
        asm_q <= sh;
        phase <= done ? '0 : phase + PW'(1);
        if (we) begin
          valid[cnt[ADDR_W-1:0]] <= 1'b1;
          cnt <= cnt + 1'b1;
        end
        if (done && full) err <= 1'b1;
      end
    end
  end
  im_word_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (cnt[ADDR_W-1:0]),
    .wdata (wr_word),
    .re    (fire),
    .raddr (bus.f_addr),
    .rdata (ram_q)
  );
  assign bus.ld_ready = state == LOAD;
  assign bus.run      = state == RUN;
  assign bus.ld_count = cnt;
  assign bus.ld_err   = err;
  assign bus.f_valid  = fv;
  assign bus.f_data   = hit ? ram_q : HALT_WORD;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed checks of load, fetch, overflow and restart behaviour.
module tb_im_loader;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int errs = 0;
  always #5 clock = ~clock;
  im_loader_if #(.ADDR_W(8), .DATA_W(16)) a ();
  im_loader_if #(.ADDR_W(2), .DATA_W(16)) b ();
  im_loader u0 (.clock(clock), .reset(reset), .bus(a));
  im_loader #(.ADDR_W(2), .DEPTH(4)) u1 (.clock(clock), .reset(reset), .bus(b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start0();
    a.ld_start = 1'b1;
    @(negedge clock);
    a.ld_start = 1'b0;
  endtask
  task automatic send0(input logic [7:0] v, input logic last);
    a.ld_byte = v; a.ld_valid = 1'b1; a.ld_last = last;
    @(negedge clock);
    a.ld_valid = 1'b0; a.ld_last = 1'b0;
  endtask
  task automatic fetch0(input string tag, input logic [7:0] addr, input logic [15:0] exp);
    a.f_req = 1'b1; a.f_addr = addr;
    @(negedge clock);
    a.f_req = 1'b0;
    check({tag, ".v"}, 32'(a.f_valid), 32'd1);
    check({tag, ".d"}, 32'(a.f_data), 32'(exp));
  endtask
  task automatic send1(input logic [7:0] v, input logic last);
    b.ld_byte = v; b.ld_valid = 1'b1; b.ld_last = last;
    @(negedge clock);
    b.ld_valid = 1'b0; b.ld_last = 1'b0;
  endtask
  task automatic fetch1(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    b.f_req = 1'b1; b.f_addr = addr;
    @(negedge clock);
    b.f_req = 1'b0;
    check({tag, ".v"}, 32'(b.f_valid), 32'd1);
    check({tag, ".d"}, 32'(b.f_data), 32'(exp));
  endtask
  initial begin
    a.ld_start = 0; a.ld_byte = 0; a.ld_valid = 0; a.ld_last = 0; a.f_req = 0; a.f_addr = 0;
    b.ld_start = 0; b.ld_byte = 0; b.ld_valid = 0; b.ld_last = 0; b.f_req = 0; b.f_addr = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("rst.f_data", 32'(a.f_data), 32'h0800);
    check("rst.f_valid", 32'(a.f_valid), 0);
    check("rst.ld_ready", 32'(a.ld_ready), 0);
    check("rst.ld_count", 32'(a.ld_count), 0);
    check("rst.ld_err", 32'(a.ld_err), 0);
    check("rst.run", 32'(a.run), 0);
    fetch0("idle0", 8'd0, 16'h0800);
    fetch0("idle200", 8'd200, 16'h0800);
    @(negedge clock);
    check("noreq.f_valid", 32'(a.f_valid), 0);
    start0();
    check("load.ld_ready", 32'(a.ld_ready), 1);
    send0(8'h4c, 0); send0(8'h04, 0); send0(8'h11, 0); send0(8'h00, 1);
    check("basic.count", 32'(a.ld_count), 2);
    check("basic.run", 32'(a.run), 1);
    check("basic.ready", 32'(a.ld_ready), 0);
    fetch0("basic0", 8'd0, 16'h4c04);
    fetch0("basic1", 8'd1, 16'h1100);
    fetch0("basic2", 8'd2, 16'h0800);
    @(negedge clock);
    check("hold.f_valid", 32'(a.f_valid), 0);
    check("hold.f_data", 32'(a.f_data), 32'h0800);
    start0();
    check("odd.count0", 32'(a.ld_count), 0);
    send0(8'ha1, 0); send0(8'hb2, 0); send0(8'hc3, 1);
    check("odd.count", 32'(a.ld_count), 2);
    fetch0("odd0", 8'd0, 16'ha1b2);
    fetch0("odd1", 8'd1, 16'hc300);
    fetch0("odd2", 8'd2, 16'h0800);
    start0();
    a.f_req = 1'b1; a.f_addr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      repeat (i + 1) begin
        @(negedge clock);
        check("gap.f_valid", 32'(a.f_valid), 0);
      end
      send0(i == 0 ? 8'h12 : i == 1 ? 8'h34 : 8'h56, i == 2);
      if (i < 2) check("gapb.f_valid", 32'(a.f_valid), 0);
    end
    a.f_req = 1'b0;
    @(negedge clock);
    fetch0("gap0", 8'd0, 16'h1234);
    fetch0("gap1", 8'd1, 16'h5600);
    start0();
    send0(8'hde, 0); send0(8'had, 0);
    check("mid.count1", 32'(a.ld_count), 1);
    a.ld_start = 1'b1; a.ld_byte = 8'hff; a.ld_valid = 1'b1;
    @(negedge clock);
    a.ld_start = 1'b0; a.ld_valid = 1'b0;
    check("restart.count", 32'(a.ld_count), 0);
    send0(8'h77, 1);
    check("restart.count1", 32'(a.ld_count), 1);
    fetch0("restart0", 8'd0, 16'h7700);
    fetch0("restart1", 8'd1, 16'h0800);
    a.ld_start = 1'b1; a.f_req = 1'b1; a.f_addr = 8'd0;
    @(negedge clock);
    a.ld_start = 1'b0; a.f_req = 1'b0;
    check("startfetch.f_valid", 32'(a.f_valid), 0);
    send0(8'h01, 0); send0(8'h02, 0); send0(8'h03, 0);
    reset = 1'b0;
    #1;
    check("rstmid.ready", 32'(a.ld_ready), 0);
    check("rstmid.count", 32'(a.ld_count), 0);
    check("rstmid.run", 32'(a.run), 0);
    @(negedge clock);
    reset = 1'b1;
    fetch0("rstmid0", 8'd0, 16'h0800);
    b.ld_start = 1'b1;
    @(negedge clock);
    b.ld_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      send1(8'(i), i == 10);
      if (i == 9) check("ovf.ready", 32'(b.ld_ready), 1);
    end
    check("ovf.count", 32'(b.ld_count), 4);
    check("ovf.err", 32'(b.ld_err), 1);
    check("ovf.run", 32'(b.run), 1);
    fetch1("ovf3", 2'd3, 16'h0708);
    fetch1("ovf0", 2'd0, 16'h0102);
    b.ld_start = 1'b1;
    @(negedge clock);
    b.ld_start = 1'b0;
    check("ovf.clr_err", 32'(b.ld_err), 0);
    check("ovf.clr_count", 32'(b.ld_count), 0);
    send1(8'hee, 1);
    fetch1("ovfn0", 2'd0, 16'hee00);
    fetch1("ovfn1", 2'd1, 16'h0800);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/im_loader.md
# im_loader

Parametrised, downloadable instruction memory for the 16-bit pipelined CPU. It replaces the fixed-content program ROM with a RAM that is filled at run time over a byte-wide valid/ready load port. Instruction fetch is a registered read with one cycle of latency. Any word that has not been written since reset or since the last load start reads as HALT, so the CPU halts cleanly on an unloaded or partially loaded program.

## Interface
Parameters:
- ADDR_W, 8, fetch/load word-address width
- DATA_W, 16, instruction width; must be a multiple of 8
- DEPTH, 2**ADDR_W, number of words
- HALT_WORD, 16'h0800, value returned for unwritten words ({HALT, 11'd0})

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- ld_start  in  1  pulse; begin a new program download
- ld_byte  in  8  download data; big-endian, first byte of each word goes to bits [DATA_W-1:DATA_W-8]
- ld_valid  in  1  ld_byte is valid
- ld_last  in  1  qualifies the final byte of the program
- ld_ready  out  1  load port can accept a byte
- ld_count  out  ADDR_W+1  words written in the current load
- ld_err  out  1  sticky overflow flag
- f_req  in  1  fetch request
- f_addr  in  ADDR_W  fetch word address
- f_data  out  DATA_W  fetched instruction
- f_valid  out  1  f_data corresponds to the request of the previous cycle
- run  out  1  memory holds a completed program

## Operation
The block has three states.

- **IDLE** (entered on reset)
  - Fetches are served; all words read HALT_WORD.
  - ld_ready=0.
  - ld_start moves to LOAD.
- **LOAD**
  - ld_ready=1. A byte is accepted when ld_valid&&ld_ready.
  - Bytes are shifted into a word assembler. When the BYTES=DATA_W/8-th byte is accepted, the word is written to address ld_count, its valid bit is set, and ld_count increments.
  - On an accepted byte with ld_last=1:
    - any partial word is zero-padded in its low bytes and written;
    - the state moves to RUN.
  - While in LOAD, fetches are dropped (f_valid=0).
- **RUN**
  - Fetches are served; ld_ready=0.
  - ld_start moves to LOAD.

Entering LOAD, from any state including LOAD itself, does all of the following in one cycle:
- clears every valid bit;
- clears ld_count, ld_err and the byte phase.

Overflow handling:
- A word completing when ld_count==DEPTH is discarded and sets ld_err.
- ld_ready stays 1 so the source can drain through ld_last.
- run is still asserted on ld_last; ld_err stays set until the next ld_start.

Read value: f_data = valid[f_addr] ? mem[f_addr] : HALT_WORD.

Simultaneous events:
- ld_start in the same cycle as ld_valid: the start wins and the byte is ignored.
- ld_start in the same cycle as f_req: the fetch is dropped.

## Timing
Reset values: f_data=HALT_WORD, f_valid=0, ld_ready=0, ld_count=0, ld_err=0, run=0. All valid bits are cleared. RAM contents are not reset.

Fetch:
- f_req=1 with f_addr=A at edge N gives f_valid=1 and f_data=word(A) after edge N+1.
- f_valid is 0 in any cycle following no request or a dropped request.
- f_data holds its previous value while f_valid=0.

Load:
- A word write and its valid bit take effect at the edge that accepts the final byte of that word.
- ld_count updates at the same edge.
- The LOAD→RUN transition and run=1 become visible the cycle after ld_last is accepted.
- ld_ready falls in that same cycle.

A reset during a load returns the block to IDLE with all words invalid.

## Structure
Package im_pkg holds:
- the 5-bit opcode constants and 3-bit register constants shared with the CPU;
- HALT_WORD;
- the state encoding IDLE/LOAD/RUN.

Sub-module im_word_ram provides the storage: DEPTH×DATA_W, one synchronous write port, one synchronous read port, no reset.

The valid-bit vector, byte assembler and state machine live in im_loader.

## Test plan
- **Fetch after reset.** Release reset, then f_req with addr 0 and addr 200 → f_valid one cycle later, f_data=16'h0800 for both.
- **Basic load and fetch.** ld_start; send bytes 4c,04,11,00 with ld_last on 00 → ld_count=2 and run=1. Then fetch addr 0 → 16'h4c04; addr 1 → 16'h1100; addr 2 → 16'h0800.
- **Odd byte count.** Send 3 bytes a1,b2,c3 with last → addr 0=16'ha1b2, addr 1=16'hc300, ld_count=2.
- **Overflow.** With DEPTH=4, send 10 bytes → ld_count=4, ld_err=1, run=1, addr 3 holds the 4th word. A following ld_start clears ld_err and all valid bits.
- **Reset and restart mid-load.** Assert reset after 3 bytes → state IDLE, addr 0 reads 16'h0800. Separately, issue ld_start mid-load → ld_count=0 and earlier words read HALT.
- **Fetch during load.** f_req held high during LOAD → f_valid stays 0 throughout. Random ld_valid gaps do not corrupt byte order.
